// File: rtl/scaler_pkg.sv
// Shared helpers for the scaler filter core: width/latency arithmetic and
// the round-and-saturate step applied to the horizontal-pass result.
package scaler_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Vertical-pass accumulator width: zero-extended pixel times signed coef,
    // summed over the taps.
    function automatic int vw_bits(input int p, input int c, input int k);
        return p + c + clog2(k) + 1;
    endfunction

    // Horizontal-pass accumulator width, no intermediate truncation.
    function automatic int hw_bits(input int p, input int c, input int k);
        return vw_bits(p, c, k) + c + clog2(k);
    endfunction

    // Two passes of (multiply + adder tree), one round stage, one FIFO register.
    function automatic int lat_cycles(input int k);
        return 2 * (1 + clog2(k)) + 2;
    endfunction

    // Round half up, then arithmetic shift out the fractional bits.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] h, input int f2);
        return (h + (64'sd1 <<< (f2 - 1))) >>> f2;
    endfunction

    function automatic logic [63:0] sat_pix(input logic signed [63:0] h, input int f2, input int pw);
        logic signed [63:0] r;
        logic signed [63:0] max;
        r   = round_shift(h, f2);
        max = (64'sd1 <<< pw) - 64'sd1;
        if (r < 0)
            return '0;
        else if (r > max)
            return max;
        else
            return r;
    endfunction

    function automatic logic sat_clip(input logic signed [63:0] h, input int f2, input int pw);
        logic signed [63:0] r;
        logic signed [63:0] max;
        r   = round_shift(h, f2);
        max = (64'sd1 <<< pw) - 64'sd1;
        return (r < 0) || (r > max);
    endfunction

endpackage

// File: rtl/scaler_dsp_mac.sv
// TAPS-wide signed multiply followed by a pipelined binary adder tree.
// Latency is 1 + clog2(TAPS) cycles; taps beyond TAPS are padded with zero.
module scaler_dsp_mac
    import scaler_pkg::*;
#(
    parameter int TAPS  = 4,
    parameter int A_W   = 9,
    parameter int B_W   = 8,
    parameter int OUT_W = 19
) (
    input  logic                    clk,
    input  logic [TAPS*A_W-1:0]     a,
    input  logic [TAPS*B_W-1:0]     b,
    output logic signed [OUT_W-1:0] sum
);

    localparam int LVLS = clog2(TAPS);
    localparam int NP   = 1 << LVLS;

    logic signed [OUT_W-1:0] tree [LVLS+1][NP];

    // Product stage, then one register per adder-tree level.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < TAPS; k++)
            tree[0][k] <= OUT_W'($signed(a[k*A_W +: A_W])) * OUT_W'($signed(b[k*B_W +: B_W]));
        for (int unsigned k = TAPS; k < NP; k++)
            tree[0][k] <= '0;
        for (int unsigned l = 0; l < LVLS; l++)
            for (int unsigned k = 0; k < (NP >> (l + 1)); k++)
                tree[l+1][k] <= tree[l][2*k] + tree[l][2*k+1];
    end

    assign sum = tree[LVLS][0];

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered output
// stage. Writes bypass storage straight into the output register when it is
// free and storage is empty.
module sync_fifo
    import scaler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop;
    logic             load;
    logic             mem_empty;
    logic             mem_rd;
    logic             mem_wr;

    // Output register refills when empty or being popped; storage is used
    // only when the write cannot go straight to the output register.
    always_comb begin
        pop       = rd_valid & rd_ready;
        load      = !rd_valid | pop;
        mem_empty = (count == '0);
        mem_rd    = load & !mem_empty;
        mem_wr    = wr_valid & !(load & mem_empty);
    end

    // Pointers, occupancy and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (mem_wr)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (mem_rd)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({mem_wr, mem_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load) begin
                if (!mem_empty) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[rd_ptr];
                end else if (wr_valid) begin
                    rd_valid <= 1'b1;
                    rd_data  <= wr_data;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/scaler_dsp_mc.sv
// Multi-channel separable polyphase filter: vertical pass, horizontal pass,
// round/saturate, then a credit-protected FWFT output FIFO.
module scaler_dsp_mc
    import scaler_pkg::*;
#(
    parameter int PIXEL_BITWIDTH       = 8,
    parameter int CHANNELS             = 3,
    parameter int KERNEL_MAX           = 4,
    parameter int KERNEL_COEF_BITWIDTH = 8,
    parameter int COEF_FRAC            = 6,
    parameter int FIFO_DEPTH           = 8
) (
    input  logic                                                       core_clk,
    input  logic                                                       core_rst,
    input  logic                                                       s_axis_scaler_valid,
    output logic                                                       s_axis_scaler_ready,
    input  logic [PIXEL_BITWIDTH*CHANNELS*KERNEL_MAX*KERNEL_MAX-1:0]   s_axis_scaler_pixel,
    input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]                 s_axis_scaler_coef_v,
    input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0]                 s_axis_scaler_coef_h,
    input  logic                                                       s_axis_scaler_done,
    output logic                                                       m_axis_core_valid,
    input  logic                                                       m_axis_core_ready,
    output logic [PIXEL_BITWIDTH*CHANNELS-1:0]                         m_axis_core_pixel,
    output logic                                                       m_axis_core_done,
    output logic [CHANNELS-1:0]                                        m_axis_core_clip
);

    localparam int P   = PIXEL_BITWIDTH;
    localparam int CH  = CHANNELS;
    localparam int K   = KERNEL_MAX;
    localparam int C   = KERNEL_COEF_BITWIDTH;
    localparam int VW  = vw_bits(P, C, K);
    localparam int HW  = hw_bits(P, C, K);
    localparam int LAT = lat_cycles(K);
    localparam int STG = 1 + clog2(K);
    localparam int F2  = 2 * COEF_FRAC;
    localparam int CW  = clog2(FIFO_DEPTH + 1);
    localparam int FW  = P * CH + CH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < LAT) begin : g_depth_check
        $error("scaler_dsp_mc: FIFO_DEPTH must be at least the pipeline latency");
    end
    if (K < 2 || K > 8) begin : g_kernel_check
        $error("scaler_dsp_mc: KERNEL_MAX must be in 2..8");
    end

    logic                    in_fire;
    logic                    pop;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic [K*(P+1)-1:0]      v_a [CH][K];
    logic signed [VW-1:0]    v_sum [CH][K];
    logic [K*VW-1:0]         h_a [CH];
    logic signed [HW-1:0]    h_sum [CH];
    logic                    vld_sr [2*STG];
    logic                    done_sr [2*STG];
    logic [K*C-1:0]          coefh_sr [STG];
    logic [P*CH-1:0]         rs_pix;
    logic [CH-1:0]           rs_clip;
    logic                    rs_valid;
    logic                    rs_done;
    logic [FW-1:0]           fifo_out;

    assign in_fire = s_axis_scaler_valid & s_axis_scaler_ready;
    assign pop     = m_axis_core_valid & m_axis_core_ready;

    // Gather each (channel, column) vertical tap set, pixels zero-extended.
    always_comb begin
        v_a = '{default: '0};
        for (int unsigned ch = 0; ch < CH; ch++)
            for (int unsigned j = 0; j < K; j++)
                for (int unsigned i = 0; i < K; i++)
                    v_a[ch][j][i*(P+1) +: (P+1)] = {1'b0, s_axis_scaler_pixel[((j*K+i)*CH+ch)*P +: P]};
    end

    // Column results of the vertical pass become the horizontal tap set.
    always_comb begin
        h_a = '{default: '0};
        for (int unsigned ch = 0; ch < CH; ch++)
            for (int unsigned j = 0; j < K; j++)
                h_a[ch][j*VW +: VW] = v_sum[ch][j];
    end

    for (genvar ch = 0; ch < CH; ch++) begin : g_ch
        for (genvar j = 0; j < K; j++) begin : g_col
            scaler_dsp_mac #(.TAPS(K), .A_W(P + 1), .B_W(C), .OUT_W(VW)) u_vmac (
                .clk (core_clk),
                .a   (v_a[ch][j]),
                .b   (s_axis_scaler_coef_v),
                .sum (v_sum[ch][j])
            );
        end
        scaler_dsp_mac #(.TAPS(K), .A_W(VW), .B_W(C), .OUT_W(HW)) u_hmac (
            .clk (core_clk),
            .a   (h_a[ch]),
            .b   (coefh_sr[STG-1]),
            .sum (h_sum[ch])
        );
    end

    // Valid and done travel alongside the data through both passes.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            for (int unsigned k = 0; k < 2 * STG; k++) begin
                vld_sr[k]  <= 1'b0;
                done_sr[k] <= 1'b0;
            end
        end else begin
            vld_sr[0]  <= in_fire;
            done_sr[0] <= s_axis_scaler_done;
            for (int unsigned k = 1; k < 2 * STG; k++) begin
                vld_sr[k]  <= vld_sr[k-1];
                done_sr[k] <= done_sr[k-1];
            end
        end
    end

    // Horizontal coefficients wait out the vertical pass to meet their beat.
    always_ff @(posedge core_clk) begin
        coefh_sr[0] <= s_axis_scaler_coef_h;
        for (int unsigned k = 1; k < STG; k++)
            coefh_sr[k] <= coefh_sr[k-1];
    end

    // Round/saturate stage feeding the FIFO write port.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            rs_valid <= 1'b0;
            rs_done  <= 1'b0;
            rs_pix   <= '0;
            rs_clip  <= '0;
        end else begin
            rs_valid <= vld_sr[2*STG-1];
            rs_done  <= done_sr[2*STG-1];
            for (int unsigned ch = 0; ch < CH; ch++) begin
                rs_pix[ch*P +: P] <= P'(sat_pix(64'(h_sum[ch]), F2, P));
                rs_clip[ch]       <= sat_clip(64'(h_sum[ch]), F2, P);
            end
        end
    end

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (core_clk),
        .rst      (core_rst),
        .wr_valid (rs_valid),
        .wr_data  ({rs_done, rs_clip, rs_pix}),
        .rd_valid (m_axis_core_valid),
        .rd_ready (m_axis_core_ready),
        .rd_data  (fifo_out)
    );

    assign {m_axis_core_done, m_axis_core_clip, m_axis_core_pixel} = fifo_out;

    // Credits: beats accepted but not yet popped, covering in-flight beats.
    always_comb begin
        cnt_next = cnt;
        if (in_fire && !pop)
            cnt_next = cnt + CW'(1);
        else if (!in_fire && pop)
            cnt_next = cnt - CW'(1);
    end

    // Credit counter and registered input ready.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            cnt                 <= '0;
            s_axis_scaler_ready <= 1'b0;
        end else begin
            cnt                 <= cnt_next;
            s_axis_scaler_ready <= (cnt_next < DEPTH_C);
        end
    end

endmodule

// File: tb/tb_scaler_dsp_mc.sv
// Directed bench for scaler_dsp_mc with the default 3-channel 4x4 configuration.
module tb_scaler_dsp_mc;

    localparam int P    = 8;
    localparam int CH   = 3;
    localparam int K    = 4;
    localparam int C    = 8;
    localparam int FD   = 8;
    localparam int PIXW = P * CH * K * K;

    logic              core_clk = 1'b0;
    logic              core_rst;
    logic              s_valid;
    logic              s_ready;
    logic [PIXW-1:0]   s_pixel;
    logic [C*K-1:0]    s_coef_v;
    logic [C*K-1:0]    s_coef_h;
    logic              s_done;
    logic              m_valid;
    logic              m_ready;
    logic [P*CH-1:0]   m_pixel;
    logic              m_done;
    logic [CH-1:0]     m_clip;

    int tests = 0;
    int fails = 0;
    int accepted;
    logic [P*CH-1:0] rx_pix [$];
    logic            rx_done [$];
    logic [P*CH-1:0] exp_q [$];

    always #5 core_clk = ~core_clk;

    scaler_dsp_mc #(
        .PIXEL_BITWIDTH       (P),
        .CHANNELS             (CH),
        .KERNEL_MAX           (K),
        .KERNEL_COEF_BITWIDTH (C),
        .COEF_FRAC            (6),
        .FIFO_DEPTH           (FD)
    ) dut (
        .core_clk             (core_clk),
        .core_rst             (core_rst),
        .s_axis_scaler_valid  (s_valid),
        .s_axis_scaler_ready  (s_ready),
        .s_axis_scaler_pixel  (s_pixel),
        .s_axis_scaler_coef_v (s_coef_v),
        .s_axis_scaler_coef_h (s_coef_h),
        .s_axis_scaler_done   (s_done),
        .m_axis_core_valid    (m_valid),
        .m_axis_core_ready    (m_ready),
        .m_axis_core_pixel    (m_pixel),
        .m_axis_core_done     (m_done),
        .m_axis_core_clip     (m_clip)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C*K-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic set_tap(input int i, input int j, input int ch, input int v);
        s_pixel[((j*K+i)*CH+ch)*P +: P] = 8'(v);
    endtask

    task automatic fill_ch(input int ch, input int v);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                set_tap(i, j, ch, v);
    endtask

    function automatic logic [P*CH-1:0] bp_pix(input int b);
        logic [P*CH-1:0] r;
        for (int ch = 0; ch < CH; ch++)
            r[ch*P +: P] = 8'(16 * b + ch + 1);
        return r;
    endfunction

    // Entered just after a negedge: note what the coming posedge commits,
    // then advance to the next negedge.
    task automatic step();
        logic fire;
        logic popd;
        fire = s_valid && s_ready;
        popd = m_valid && m_ready;
        if (popd) begin
            rx_pix.push_back(m_pixel);
            rx_done.push_back(m_done);
        end
        @(negedge core_clk);
        if (fire)
            accepted++;
    endtask

    // Present the current beat until accepted, then wait for the first output.
    task automatic send_one(output int lat);
        int g;
        accepted = 0;
        s_valid  = 1'b1;
        g = 0;
        while (accepted == 0 && g < 20) begin
            step();
            g++;
        end
        s_valid = 1'b0;
        s_done  = 1'b0;
        lat = 1;
        while (!m_valid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int g;
        core_rst = 1'b1;
        s_valid  = 1'b0;
        s_pixel  = '0;
        s_coef_v = '0;
        s_coef_h = '0;
        s_done   = 1'b0;
        m_ready  = 1'b0;
        accepted = 0;
        repeat (3) @(negedge core_clk);

        check("rst_m_valid", m_valid, 0);
        check("rst_m_pixel", m_pixel, 0);
        check("rst_m_done", m_done, 0);
        check("rst_m_clip", m_clip, 0);
        check("rst_s_ready", s_ready, 0);
        core_rst = 1'b0;
        step();
        check("ready_after_release", s_ready, 1);

        // Identity kernel: output is the centre tap (1,1) of each channel.
        m_ready  = 1'b1;
        s_coef_v = pack4(0, 64, 0, 0);
        s_coef_h = pack4(0, 64, 0, 0);
        for (int ch = 0; ch < CH; ch++) fill_ch(ch, 8'hAA);
        set_tap(1, 1, 0, 8'h37);
        set_tap(1, 1, 1, 8'hC8);
        set_tap(1, 1, 2, 8'h01);
        s_done = 1'b1;
        send_one(lat);
        check("id_accept", accepted, 1);
        check("id_latency", lat, 8);
        check("id_pixel", m_pixel, 24'h01C837);
        check("id_clip", m_clip, 0);
        check("id_done", m_done, 1);
        step();

        // Sharpen: ch0 lone 255 overshoots, ch1 inverted undershoots, ch2 flat.
        s_coef_v = pack4(-8, 80, 0, -8);
        s_coef_h = pack4(-8, 80, 0, -8);
        s_pixel  = '0;
        set_tap(1, 1, 0, 255);
        fill_ch(1, 255);
        set_tap(1, 1, 1, 0);
        fill_ch(2, 100);
        send_one(lat);
        check("sharp_valid", m_valid, 1);
        check("sharp_pixel", m_pixel, {8'd100, 8'd0, 8'd255});
        check("sharp_clip", m_clip, 3'b011);
        check("sharp_done", m_done, 0);
        step();

        // Rounding at the half boundary: H = 153600 -> 38, 153599 -> 37, 153601 -> 38.
        s_coef_v = pack4(64, 1, 0, 0);
        s_coef_h = pack4(40, 1, 0, 0);
        s_pixel  = '0;
        set_tap(0, 0, 0, 60);
        set_tap(0, 0, 1, 59);
        set_tap(1, 0, 1, 63);
        set_tap(1, 1, 1, 39);
        set_tap(0, 0, 2, 60);
        set_tap(1, 1, 2, 1);
        send_one(lat);
        check("round_pixel", m_pixel, {8'd38, 8'd37, 8'd38});
        check("round_clip", m_clip, 0);
        step();

        // Back-to-back random beats through the identity kernel.
        s_coef_v = pack4(0, 64, 0, 0);
        s_coef_h = pack4(0, 64, 0, 0);
        rx_pix.delete();
        rx_done.delete();
        exp_q.delete();
        accepted = 0;
        g = 0;
        s_valid = 1'b1;
        while (accepted < 6 && g < 30) begin
            if (exp_q.size() == accepted) begin
                for (int w = 0; w < PIXW / 32; w++) s_pixel[w*32 +: 32] = $urandom();
                exp_q.push_back({s_pixel[((1*K+1)*CH+2)*P +: P],
                                 s_pixel[((1*K+1)*CH+1)*P +: P],
                                 s_pixel[((1*K+1)*CH+0)*P +: P]});
            end
            step();
            g++;
        end
        s_valid = 1'b0;
        check("tput_steps", g, 6);
        g = 0;
        while (rx_pix.size() < 6 && g < 30) begin
            step();
            g++;
        end
        check("tput_count", rx_pix.size(), 6);
        for (int b = 0; b < 6 && b < rx_pix.size(); b++)
            check($sformatf("tput_pix%0d", b), rx_pix[b], exp_q[b]);

        // Backpressure: downstream stalled, continuous input.
        m_ready = 1'b0;
        rx_pix.delete();
        rx_done.delete();
        accepted = 0;
        s_pixel  = '0;
        for (int c = 0; c < 20; c++) begin
            for (int ch = 0; ch < CH; ch++) set_tap(1, 1, ch, 16 * accepted + ch + 1);
            s_done  = (accepted == 5);
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        s_done  = 1'b0;
        check("bp_accepted", accepted, 8);
        check("bp_ready_low", s_ready, 0);
        check("bp_hold_valid", m_valid, 1);
        check("bp_hold_pixel", m_pixel, bp_pix(0));
        m_ready = 1'b1;
        step();
        check("bp_ready_reassert", s_ready, 1);
        g = 0;
        while (rx_pix.size() < 8 && g < 20) begin
            step();
            g++;
        end
        repeat (5) step();
        check("bp_rx_count", rx_pix.size(), 8);
        for (int b = 0; b < 8 && b < rx_pix.size(); b++) begin
            check($sformatf("bp_pix%0d", b), rx_pix[b], bp_pix(b));
            check($sformatf("bp_done%0d", b), rx_done[b], (b == 5));
        end

        // Reset with beats in flight and buffered.
        m_ready  = 1'b0;
        accepted = 0;
        g = 0;
        s_valid = 1'b1;
        while (accepted < 5 && g < 20) begin
            for (int ch = 0; ch < CH; ch++) set_tap(1, 1, ch, 16 * accepted + ch + 1);
            step();
            g++;
        end
        s_valid = 1'b0;
        repeat (4) step();
        check("mid_pre_valid", m_valid, 1);
        core_rst = 1'b1;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_pixel", m_pixel, 0);
        check("mid_rst_done", m_done, 0);
        check("mid_rst_ready", s_ready, 0);
        repeat (2) @(negedge core_clk);
        core_rst = 1'b0;
        m_ready  = 1'b1;
        rx_pix.delete();
        rx_done.delete();
        s_pixel = '0;
        set_tap(1, 1, 0, 8'hE1);
        set_tap(1, 1, 1, 8'hE2);
        set_tap(1, 1, 2, 8'hE3);
        send_one(lat);
        check("post_rst_latency", lat, 8);
        check("post_rst_pixel", m_pixel, 24'hE3E2E1);
        repeat (10) step();
        check("post_rst_count", rx_pix.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
